load_store_buffer: RTL

- In-order load/store queue that receives ROB dispatches of memory ops and issues them to data memory.
- Issue happens only after the ROB grants commit via ls_commit/ls_num_out.
- Reports operand-ready entries to the ROB on ready_load_num and broadcasts completed results on mem_num/mem_value.
- Sits between ROB dispatch, the ALU/commit broadcast buses and the data-memory port.

---
 rtl/load_store_buffer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_buffer.sv
// In-order load/store queue: holds dispatched memory ops, wakes operands from broadcast buses,
// issues the head to data memory once the ROB grants it, and pulses the completed result.
module load_store_buffer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       op_in,
  input  logic [31:0]      value1_in,
  input  logic [TAG_W-1:0] query1_in,
  input  logic [31:0]      value2_in,
  input  logic [TAG_W-1:0] query2_in,
  input  logic [31:0]      imm_in,
  input  logic [TAG_W-1:0] target_in,
  input  logic [TAG_W-1:0] alu_num,
  input  logic [31:0]      alu_value,
  input  logic             commit,
  input  logic [TAG_W-1:0] num_out,
  input  logic [31:0]      value_out,
  input  logic             ls_commit,
  input  logic [TAG_W-1:0] ls_num_out,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_done,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [1:0]       mem_size,
  output logic [TAG_W-1:0] mem_num,
  output logic [31:0]      mem_value,
  output logic [TAG_W-1:0] ready_load_num,
  output logic             lsb_full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH - 1);

  localparam logic [4:0] OP_LB = 5'b10010, OP_LH = 5'b10011, OP_LW = 5'b10100,
                         OP_LBU = 5'b10101, OP_LHU = 5'b10110, OP_SB = 5'b10111,
                         OP_SH = 5'b11000, OP_SW = 5'b11001;

  typedef struct packed {
    logic [4:0]       op;
    logic [31:0]      v1;
    logic [TAG_W-1:0] q1;
    logic [31:0]      v2;
    logic [TAG_W-1:0] q2;
    logic [31:0]      imm;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  entry_t           ent    [DEPTH];
  entry_t           ent_wk [DEPTH];
  entry_t           disp_wk;
  entry_t           head_e;
  logic [DEPTH-1:0] vld;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  state_t           state;
  logic             do_disp, do_pop, head_rdy, grant;

  function automatic logic is_load(input logic [4:0] op);
    return op <= OP_LHU;
  endfunction

  function automatic logic [1:0] size_of(input logic [4:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 2'b00;
      OP_LH, OP_LHU, OP_SH: return 2'b01;
      default:              return 2'b10;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [4:0] op, input logic [31:0] d);
    case (op)
      OP_LB:   return {{24{d[7]}}, d[7:0]};
      OP_LBU:  return {24'b0, d[7:0]};
      OP_LH:   return {{16{d[15]}}, d[15:0]};
      OP_LHU:  return {16'b0, d[15:0]};
      OP_LW:   return d;
      default: return 32'b0;
    endcase
  endfunction

  // Tags are unique system-wide, so at most one bus can match a given producer tag.
  function automatic logic bc_hit(input logic [TAG_W-1:0] q);
    return (q != '0) && ((q == alu_num) || (commit && q == num_out) || (q == mem_num));
  endfunction

  function automatic logic [31:0] bc_val(input logic [TAG_W-1:0] q);
    if (q == alu_num)            return alu_value;
    else if (commit && q == num_out) return value_out;
    else                         return mem_value;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_wk[i] = ent[i];
      if (bc_hit(ent[i].q1)) begin
        ent_wk[i].v1 = bc_val(ent[i].q1);
        ent_wk[i].q1 = '0;
      end
      if (bc_hit(ent[i].q2)) begin
        ent_wk[i].v2 = bc_val(ent[i].q2);
        ent_wk[i].q2 = '0;
      end
    end
    disp_wk = '{op: op_in, v1: value1_in, q1: query1_in, v2: value2_in,
                q2: query2_in, imm: imm_in, tag: target_in};
    if (bc_hit(query1_in)) begin
      disp_wk.v1 = bc_val(query1_in);
      disp_wk.q1 = '0;
    end
    if (bc_hit(query2_in)) begin
      disp_wk.v2 = bc_val(query2_in);
      disp_wk.q2 = '0;
    end
  end

  assign head_e   = ent[head];
  assign head_rdy = vld[head] && (head_e.q1 == '0) && (is_load(head_e.op) || head_e.q2 == '0);
  assign grant    = (state == IDLE) && ls_commit && (ls_num_out == head_e.tag) && head_rdy;
  assign do_disp  = (op_in >= OP_LB) && (op_in <= OP_SW) && (count < CNT_MAX);
  assign do_pop   = (state == RESP);
  assign lsb_full = (count >= CNT_FULL);

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld            <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      state          <= IDLE;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_size       <= '0;
      mem_num        <= '0;
      mem_value      <= '0;
      ready_load_num <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld[i]) ent[i] <= ent_wk[i];
      end
      if (do_disp) begin
        ent[tail] <= disp_wk;
        vld[tail] <= 1'b1;
        tail      <= tail + PTR_W'(1);
      end
      case ({do_disp, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      mem_num   <= '0;
      mem_value <= '0;
      case (state)
        IDLE: begin
          if (grant) begin
            state          <= MEM;
            mem_req        <= 1'b1;
            mem_we         <= !is_load(head_e.op);
            mem_addr       <= head_e.v1 + head_e.imm;
            mem_wdata      <= head_e.v2;
            mem_size       <= size_of(head_e.op);
            ready_load_num <= '0;
          end else begin
            ready_load_num <= head_rdy ? head_e.tag : '0;
          end
        end
        MEM: begin
          ready_load_num <= '0;
          if (mem_done) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_num   <= head_e.tag;
            mem_value <= is_load(head_e.op) ? load_ext(head_e.op, mem_rdata) : 32'b0;
          end
        end
        default: begin
          ready_load_num <= '0;
          vld[head]      <= 1'b0;
          head           <= head + PTR_W'(1);
          state          <= IDLE;
        end
      endcase
    end
  end
endmodule
